mm_feed_buffer: RTL

MM_FEED_BUFFER -- requirements
Module: mm_feed_buffer

---
 rtl/mm_feed_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mm_feed_buffer.sv
// Matrix-unit feed buffer: fetches RAM rows for one command and presents them
// to the MXU lanes, either as per-lane column streams (MODE 0) or as a
// diagonally skewed wavefront (MODE 1).
module mm_feed_buffer #(
  parameter int unsigned DIM  = 16,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 12,
  parameter int unsigned MODE = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_vld,
  output logic                                 cmd_rdy,
  input  logic [$clog2(DIM)-1:0]               cmd_row_len,
  input  logic [$clog2(DIM)-1:0]               cmd_col_len,
  input  logic [AW-1:0]                        cmd_start_addr,
  output logic                                 ram_rd_vld,
  output logic [AW-$clog2(DIM*DW/8)-1:0]       ram_rd_addr,
  input  logic                                 ram_rd_gnt,
  input  logic                                 ram_rsp_vld,
  input  logic [DIM*DW-1:0]                    ram_rsp_data,
  input  logic                                 mxu_stall,
  output logic [DIM-1:0]                       mxu_vld,
  output logic [DIM*DW-1:0]                    mxu_data,
  output logic                                 mxu_end,
  output logic                                 busy
);

  localparam int unsigned LW   = $clog2(DIM);
  localparam int unsigned CW   = LW + 1;
  localparam int unsigned RD_W = DIM * DW;
  localparam int unsigned OB   = $clog2(DIM * DW / 8);
  localparam int unsigned EB   = $clog2(DW / 8);
  localparam int unsigned RW   = AW - OB;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              end_d;
  logic [LW-1:0]     row_len_q, col_len_q, off_q;
  logic [RW-1:0]     base_q;
  logic [CW-1:0]     rd_cnt_q, rsp_cnt_q, total;
  logic              hold_vld_q;
  logic [RD_W-1:0]   hold_data_q;
  logic [RD_W-1:0]   lane_q [DIM];
  logic [DIM-1:0]    vld_q;
  logic              accept, grant, rsp_ok, capture, apply;
  logic [RD_W-1:0]   rot_data, apply_data;

  assign cmd_rdy     = (state_q == S_IDLE);
  assign busy        = ~cmd_rdy;
  assign accept      = cmd_vld & cmd_rdy;
  assign ram_rd_vld  = (state_q == S_FETCH) & ~mxu_stall & ~hold_vld_q;
  assign grant       = ram_rd_vld & ram_rd_gnt;
  assign total       = CW'(row_len_q) + CW'(1);
  assign ram_rd_addr = base_q + RW'(rd_cnt_q);
  assign mxu_vld     = vld_q;

  // A response is usable only mid-command, with the hold slot free and rows outstanding.
  assign rsp_ok     = ram_rsp_vld & (state_q != S_IDLE) & ~hold_vld_q & (rsp_cnt_q < total);
  assign capture    = rsp_ok & mxu_stall;
  assign apply      = ~mxu_stall & (hold_vld_q | rsp_ok);
  assign apply_data = hold_vld_q ? hold_data_q : rot_data;

  // Rotate the returned row so lane k holds element (k + off) mod DIM.
  always_comb begin
    rot_data = '0;
    for (int k = 0; k < DIM; k++) begin
      rot_data[k*DW +: DW] = ram_rsp_data[((k + int'(off_q)) % DIM)*DW +: DW];
    end
  end

  // Next-state logic: fetch all rows, then wait for the lanes to drain.
  always_comb begin
    state_d = state_q;
    end_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: if (grant && rd_cnt_q == CW'(row_len_q)) state_d = S_DRAIN;
      S_DRAIN: if (rsp_cnt_q == total && vld_q == '0) begin
        state_d = S_IDLE;
        end_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and end-of-command pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mxu_end <= 1'b0;
    end else begin
      state_q <= state_d;
      mxu_end <= end_d;
    end
  end

  // Command latch, read/response counters and the one-entry hold slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_len_q   <= '0;
      col_len_q   <= '0;
      off_q       <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      rsp_cnt_q   <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else if (accept) begin
      row_len_q   <= cmd_row_len;
      col_len_q   <= cmd_col_len;
      off_q       <= cmd_start_addr[EB +: LW];
      base_q      <= cmd_start_addr[OB +: RW];
      rd_cnt_q    <= '0;
      rsp_cnt_q   <= '0;
      hold_vld_q  <= 1'b0;
    end else begin
      if (grant) rd_cnt_q <= rd_cnt_q + CW'(1);
      if (apply) rsp_cnt_q <= rsp_cnt_q + CW'(1);
      if (capture) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= rot_data;
      end else if (apply) begin
        hold_vld_q  <= 1'b0;
      end
    end
  end

  if (MODE == 0) begin : g_col
    logic [LW-1:0] cnt_q [DIM];

    // Row j fills lane j, which then streams one element per unstalled cycle.
    always_ff @(posedge clk) begin
      if (rst || accept) begin
        vld_q <= '0;
        for (int i = 0; i < DIM; i++) begin
          lane_q[i] <= '0;
          cnt_q[i]  <= '0;
        end
      end else if (!mxu_stall) begin
        for (int i = 0; i < DIM; i++) begin
          if (apply && LW'(i) == rsp_cnt_q[LW-1:0]) begin
            lane_q[i] <= apply_data;
            vld_q[i]  <= 1'b1;
            cnt_q[i]  <= col_len_q;
          end else if (vld_q[i]) begin
            lane_q[i] <= {lane_q[i][DW-1:0], lane_q[i][RD_W-1:DW]};
            if (cnt_q[i] == '0) vld_q[i] <= 1'b0;
            else                cnt_q[i] <= cnt_q[i] - LW'(1);
          end
        end
      end
    end

    // Each valid lane presents element 0 of its register.
    always_comb begin
      mxu_data = '0;
      for (int i = 0; i < DIM; i++) begin
        if (vld_q[i]) mxu_data[i*DW +: DW] = lane_q[i][DW-1:0];
      end
    end
  end else begin : g_diag
    // Rows enter lane 0 and ripple one lane per unstalled cycle.
    always_ff @(posedge clk) begin
      if (rst || accept) begin
        vld_q <= '0;
        for (int i = 0; i < DIM; i++) lane_q[i] <= '0;
      end else if (!mxu_stall) begin
        if (apply) lane_q[0] <= apply_data;
        vld_q[0] <= apply;
        for (int i = 1; i < DIM; i++) begin
          lane_q[i] <= lane_q[i-1];
          vld_q[i]  <= vld_q[i-1] & (LW'(i) <= col_len_q);
        end
      end
    end

    // Lane i presents element i of its register, forming the skew.
    always_comb begin
      mxu_data = '0;
      for (int i = 0; i < DIM; i++) begin
        if (vld_q[i]) mxu_data[i*DW +: DW] = lane_q[i][i*DW +: DW];
      end
    end
  end

endmodule
